// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU with in_valid/out_valid handshake.
// Optional macro DIV_EARLY_TERM_EN: finish in one cycle when srcb==0 or |srca| < |srcb|.
module divider_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             cancel,
    input  logic             sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] step_rem, step_q;
    logic             unused_trial;
`ifdef DIV_EARLY_TERM_EN
    logic             early;
`endif

    always_comb begin
        accept    = in_valid & ~cancel;
        last_step = (cnt_q == '0);
        abs_a     = (sign & srca[WIDTH-1]) ? -srca : srca;
        abs_b     = (sign & srcb[WIDTH-1]) ? -srcb : srcb;
`ifdef DIV_EARLY_TERM_EN
        early     = (srcb == '0) | (abs_a < abs_b);
`endif
        // Shift in the next dividend bit; a non-negative trial means the divisor fits.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};
        if (!trial[WIDTH+1]) begin
            step_rem = trial[WIDTH-1:0];
            step_q   = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_q   = {dvd_q[WIDTH-2:0], 1'b0};
        end
        unused_trial = trial[WIDTH];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_TERM_EN
                    state_d = early ? S_DONE : S_BUSY;
`else
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (cancel)         state_d = S_IDLE;
                else if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == S_DONE) & ~cancel;
        busy      = (state_q != S_IDLE);
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        if (state_q == S_IDLE && accept) begin
            rem_d  = '0;
            dvd_d  = abs_a;
            dvs_d  = abs_b;
            cnt_d  = CW'(WIDTH - 1);
            qneg_d = sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            rneg_d = sign & srca[WIDTH-1];
            dz_d   = (srcb == '0);
`ifdef DIV_EARLY_TERM_EN
            if (early) begin
                hi_d = srca;
                lo_d = (srcb == '0) ? '1 : '0;
            end
`endif
        end else if (state_q == S_BUSY && !cancel) begin
            rem_d = step_rem;
            dvd_d = step_q;
            if (last_step) begin
                // Sign correction folds into the final step so DONE presents the result.
                lo_d = dz_q ? '1 : (qneg_q ? -step_q : step_q);
                hi_d = rneg_q ? -step_rem : step_rem;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
        dz_q   <= dz_d;
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: arithmetic reference model, directed and random divides.
module tb_divider_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         cancel = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    divider_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .cancel    (cancel),
        .sign      (sign),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, MIPS conventions, special cases from the rules.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] mlo, output logic [W-1:0] mhi,
                                  output int lat);
        longint sa, sb;
`ifdef DIV_EARLY_TERM_EN
        logic [W-1:0] aa, ab;
`endif
        if (b == '0) begin
            mlo = '1;
            mhi = a;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            mlo = W'(sa / sb);
            mhi = W'(sa % sb);
        end else begin
            mlo = a / b;
            mhi = a % b;
        end
        lat = W;
`ifdef DIV_EARLY_TERM_EN
        aa = (s && a[W-1]) ? -a : a;
        ab = (s && b[W-1]) ? -b : b;
        if (b == '0 || aa < ab) lat = 1;
`endif
    endfunction

    // Single compare process: every result pulse is matched to the oldest accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: got out_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit drop, output int pulse);
        exp_t e;
        int   n;
        sign     = s;
        srca     = a;
        srcb     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        model(s, a, b, e.lo, e.hi, e.lat);
        e.acc = cyc;
        exp_q.push_back(e);
        n     = 0;
        pulse = -1;
        while (pulse < 0 && n < 100) begin
            @(negedge clk);
            if (out_valid) pulse = cyc;
            n++;
        end
        if (pulse < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no out_valid in %0d cycles expected one", n);
            exp_q.delete();
        end
        #1;
        if (drop) in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] mlo, mhi;
        int           mlat;
        int           p1, p2;
        logic         s;
        logic [W-1:0] a, b;
        int           sel;

        // Pin the model against hand-computed values.
        model(1'b0, 32'd100, 32'd7, mlo, mhi, mlat);
        chk("model_divu_100_7_lo", mlo, 32'd14);
        chk("model_divu_100_7_hi", mhi, 32'd2);
        model(1'b1, 32'hFFFF_FFF9, 32'd2, mlo, mhi, mlat);
        chk("model_div_m7_2_lo", mlo, 32'hFFFF_FFFD);
        chk("model_div_m7_2_hi", mhi, 32'hFFFF_FFFF);
        model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mlo, mhi, mlat);
        chk("model_ovf_lo", mlo, 32'h8000_0000);
        chk("model_ovf_hi", mhi, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(1);

        run_op(1'b0, 32'd100, 32'd7, 1'b1, p1);
        chk("divu_100_7_lo", lo, 32'd14);
        chk("divu_100_7_hi", hi, 32'd2);
        chk("idle_after_done", 32'(busy), 32'd0);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, p1);
        chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, p1);
        chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7_m2_hi", hi, 32'd1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, p1);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        run_op(1'b0, 32'd5, 32'd0, 1'b1, p1);
        chk("divu_5_0_lo", lo, 32'hFFFF_FFFF);
        chk("divu_5_0_hi", hi, 32'd5);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, p1);
        chk("div_m5_0_lo", lo, 32'hFFFF_FFFF);
        chk("div_m5_0_hi", hi, 32'hFFFF_FFFB);
        run_op(1'b0, 32'd3, 32'd9, 1'b1, p1);
        chk("divu_3_9_lo", lo, 32'd0);
        chk("divu_3_9_hi", hi, 32'd3);

        // Cancel mid-divide: no pulse, back to idle, hi/lo untouched.
        sign = 1'b0; srca = 32'd1000; srcb = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(8);
        cancel = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_out_valid", 32'(out_valid), 32'd0);
        idle_cycles(40);
        chk("cancel_hi_kept", hi, 32'd3);
        chk("cancel_lo_kept", lo, 32'd0);
        run_op(1'b0, 32'd9, 32'd3, 1'b1, p1);
        chk("divu_9_3_lo", lo, 32'd3);
        chk("divu_9_3_hi", hi, 32'd0);

        // Back-to-back with in_valid held high across both requests.
        run_op(1'b0, 32'd20, 32'd3, 1'b0, p1);
        chk("b2b_first_lo", lo, 32'd6);
        chk("b2b_first_hi", hi, 32'd2);
        run_op(1'b0, 32'd21, 32'd4, 1'b1, p2);
        chk("b2b_second_lo", lo, 32'd5);
        chk("b2b_second_hi", hi, 32'd1);
        chk("b2b_spacing", 32'(p2 - p1), 32'(W + 2));

        // Reset mid-divide drops it and clears the outputs.
        sign = 1'b0; srca = 32'd20; srcb = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle_cycles(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        idle_cycles(40);

        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                1: b = $urandom_range(1, 15);
                2: b = '0;
                3: begin
                    a = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 0) b = 32'hFFFF_FFFF;
                end
                4: begin
                    a = $urandom_range(0, 50);
                    b = $urandom_range(51, 1000);
                end
                5: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(s, a, b, 1'($urandom_range(0, 1)), p1);
        end
        in_valid = 1'b0;
        idle_cycles(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
